// File: rtl/out_alu_control_unit_pkg.sv
// Purpose : shared op codes, write-FSM encoding and default widths for the result-side control unit.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package out_alu_control_unit_pkg;

    localparam int DATA_SIZE_DEF      = 16;
    localparam int ID_SIZE_DEF        = 8;
    localparam int OPERATION_SIZE_DEF = 2;

    // Same op encoding as the FIFO_IN->ALU side.
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } wr_state_t;

endpackage

// File: rtl/d_ff_async_en.sv
// Purpose : WIDTH-bit register, async active-low reset to zero, load enable.
// Latency : 1 cycle from d to q when en is high.
// Backpressure: none; en is the only hold control.
// Ports   : clk, rst_n, en, d[WIDTH] -> q[WIDTH]
module d_ff_async_en #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/out_alu_result_slot.sv
// Purpose : one-deep holding slot for an ALU result channel ({result, id} + held flag).
// Latency : captured on the valid&ready edge, visible (held=1) the cycle after.
// Backpressure: ready = !held, a pure register output; a held result is never overwritten.
// Ports   : clk, rst_n, valid, result, id, clr (drain strobe) -> ready, held, res_q, id_q
import out_alu_control_unit_pkg::*;

module out_alu_result_slot #(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int ID_SIZE   = ID_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid,
    input  logic [DATA_SIZE-1:0] result,
    input  logic [ID_SIZE-1:0]   id,
    input  logic                 clr,
    output logic                 ready,
    output logic                 held,
    output logic [DATA_SIZE-1:0] res_q,
    output logic [ID_SIZE-1:0]   id_q
);

    logic capture;

    // capture needs !held and clr is only issued while held, so the two
    // never collide and the held flag can simply load 'capture'.
    assign capture = valid & ~held;
    assign ready   = ~held;

    d_ff_async_en #(.WIDTH(1)) u_held_ff (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (capture | clr),
        .d     (capture),
        .q     (held)
    );

    d_ff_async_en #(.WIDTH(DATA_SIZE + ID_SIZE)) u_data_ff (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (capture),
        .d     ({result, id}),
        .q     ({res_q, id_q})
    );

endmodule

// File: rtl/out_alu_control_unit.sv
// Purpose : collects adder/multiplier results and writes {result, id, op} into FIFO_OUT as single pulses.
// Latency : capture at edge k -> w_en_out high in the cycle after edge k+1 (FIFO_OUT not full); max 1 write / 2 cycles.
// Backpressure: full_out blocks grants; held channels keep ready low until drained.
// Ports   : clk, rst_n; adder a_valid_result/add_result/id_add_out -> a_ready_result;
//           multiplier m_valid_result/mul_result/id_mul_out -> m_ready_result;
//           full_out -> w_en_out, fifo_out_data; busy.
// Config  : OUT_ALU_RR_ARB_EN defined -> round-robin between channels on contention;
//           undefined -> fixed priority, adder wins.
import out_alu_control_unit_pkg::*;

module out_alu_control_unit #(
    parameter int DATA_SIZE      = DATA_SIZE_DEF,
    parameter int ID_SIZE        = ID_SIZE_DEF,
    parameter int OPERATION_SIZE = OPERATION_SIZE_DEF,
    parameter int FIFO_OUT_WIDTH = DATA_SIZE + ID_SIZE + OPERATION_SIZE
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      a_valid_result,
    input  logic [DATA_SIZE-1:0]      add_result,
    input  logic [ID_SIZE-1:0]        id_add_out,
    output logic                      a_ready_result,
    input  logic                      m_valid_result,
    input  logic [DATA_SIZE-1:0]      mul_result,
    input  logic [ID_SIZE-1:0]        id_mul_out,
    output logic                      m_ready_result,
    input  logic                      full_out,
    output logic                      w_en_out,
    output logic [FIFO_OUT_WIDTH-1:0] fifo_out_data,
    output logic                      busy
);

    logic                      held_a, held_m;
    logic [DATA_SIZE-1:0]      res_a, res_m;
    logic [ID_SIZE-1:0]        id_a, id_m;
    logic                      grant, pick_mul;
    logic                      clr_a, clr_m;
    logic                      state_bit;
    wr_state_t                 state_q, state_d;
    logic [OPERATION_SIZE-1:0] op_sel;
    logic [FIFO_OUT_WIDTH-1:0] word_d;

    assign clr_a = grant & ~pick_mul;
    assign clr_m = grant &  pick_mul;

    out_alu_result_slot #(.DATA_SIZE(DATA_SIZE), .ID_SIZE(ID_SIZE)) u_slot_add (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  (a_valid_result),
        .result (add_result),
        .id     (id_add_out),
        .clr    (clr_a),
        .ready  (a_ready_result),
        .held   (held_a),
        .res_q  (res_a),
        .id_q   (id_a)
    );

    out_alu_result_slot #(.DATA_SIZE(DATA_SIZE), .ID_SIZE(ID_SIZE)) u_slot_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  (m_valid_result),
        .result (mul_result),
        .id     (id_mul_out),
        .clr    (clr_m),
        .ready  (m_ready_result),
        .held   (held_m),
        .res_q  (res_m),
        .id_q   (id_m)
    );

    // Write FSM state register.
    d_ff_async_en #(.WIDTH(1)) u_state_ff (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .d     (state_d),
        .q     (state_bit)
    );
    assign state_q = wr_state_t'(state_bit);

`ifdef OUT_ALU_RR_ARB_EN
    // ptr_q = 1 favours the multiplier on the next contested grant.
    logic ptr_q, ptr_d, ptr_en;

    d_ff_async_en #(.WIDTH(1)) u_ptr_ff (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ptr_en),
        .d     (ptr_d),
        .q     (ptr_q)
    );
`endif

    // Grants are only issued from IDLE, so full_out is always sampled after
    // the previous write pulse has reached FIFO_OUT.
    always_comb begin
        state_d  = state_q;
        grant    = 1'b0;
        pick_mul = 1'b0;
`ifdef OUT_ALU_RR_ARB_EN
        ptr_d    = ptr_q;
        ptr_en   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!full_out && (held_a || held_m)) begin
                    grant   = 1'b1;
                    state_d = ST_WRITE;
`ifdef OUT_ALU_RR_ARB_EN
                    pick_mul = held_m && (!held_a || ptr_q);
                    if (held_a && held_m) begin
                        ptr_en = 1'b1;
                        ptr_d  = ~pick_mul;   // hand priority to the loser
                    end
`else
                    pick_mul = !held_a;
`endif
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign op_sel = pick_mul ? OPERATION_SIZE'(OP_MUL) : OPERATION_SIZE'(OP_ADD);
    assign word_d = pick_mul ? {res_m, id_m, op_sel} : {res_a, id_a, op_sel};

    // Strobe is high exactly in the cycle after a grant edge.
    d_ff_async_en #(.WIDTH(1)) u_wen_ff (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .d     (grant),
        .q     (w_en_out)
    );

    // Word is only loaded on a grant, so it holds its value between writes.
    d_ff_async_en #(.WIDTH(FIFO_OUT_WIDTH)) u_word_ff (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (grant),
        .d     (word_d),
        .q     (fifo_out_data)
    );

    assign busy = held_a | held_m | w_en_out;

endmodule

// File: tb/tb_out_alu_control_unit.sv
module tb_out_alu_control_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid_result = 1'b0;
    logic [15:0] add_result = '0;
    logic [7:0]  id_add_out = '0;
    logic        a_ready_result;
    logic        m_valid_result = 1'b0;
    logic [15:0] mul_result = '0;
    logic [7:0]  id_mul_out = '0;
    logic        m_ready_result;
    logic        full_out = 1'b0;
    logic        w_en_out;
    logic [25:0] fifo_out_data;
    logic        busy;

    out_alu_control_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .a_valid_result (a_valid_result),
        .add_result     (add_result),
        .id_add_out     (id_add_out),
        .a_ready_result (a_ready_result),
        .m_valid_result (m_valid_result),
        .mul_result     (mul_result),
        .id_mul_out     (id_mul_out),
        .m_ready_result (m_ready_result),
        .full_out       (full_out),
        .w_en_out       (w_en_out),
        .fifo_out_data  (fifo_out_data),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Each channel is a one-entry mailbox; a write needs a quiet cycle after
    // the previous one and FIFO_OUT not full; contested writes follow the
    // arbitration rule. Expected words go into exp_q in write order.
    logic        mh_a = 1'b0, mh_m = 1'b0;
    logic [15:0] mr_a = '0, mr_m = '0;
    logic [7:0]  mi_a = '0, mi_m = '0;
    logic        m_wen = 1'b0;
    logic        m_ptr_mul = 1'b0;
    logic        take_a, take_m, prev_w, win_mul;
    int          acc_a = 0, acc_m = 0;
    logic [25:0] exp_q[$];
    logic [1:0]  wlog[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mh_a = 1'b0; mh_m = 1'b0; m_wen = 1'b0; m_ptr_mul = 1'b0;
            exp_q.delete();
        end else begin
            take_a = a_valid_result && !mh_a;
            take_m = m_valid_result && !mh_m;
            prev_w = m_wen;
            m_wen  = 1'b0;
            if (!prev_w && !full_out && (mh_a || mh_m)) begin
                if (mh_a && mh_m) begin
`ifdef OUT_ALU_RR_ARB_EN
                    win_mul   = m_ptr_mul;
                    m_ptr_mul = !win_mul;
`else
                    win_mul = 1'b0;
`endif
                end else begin
                    win_mul = mh_m;
                end
                if (win_mul) begin
                    exp_q.push_back({mr_m, mi_m, 2'b10});
                    mh_m = 1'b0;
                end else begin
                    exp_q.push_back({mr_a, mi_a, 2'b01});
                    mh_a = 1'b0;
                end
                m_wen = 1'b1;
            end
            if (take_a) begin mh_a = 1'b1; mr_a = add_result; mi_a = id_add_out; acc_a++; end
            if (take_m) begin mh_m = 1'b1; mr_m = mul_result; mi_m = id_mul_out; acc_m++; end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic        prev_wen = 1'b0;
    logic [25:0] exp_word;

    always @(negedge clk) begin
        if (rst_n) begin
            check("w_en_out", w_en_out, m_wen);
            check("a_ready", a_ready_result, !mh_a);
            check("m_ready", m_ready_result, !mh_m);
            check("busy", busy, mh_a | mh_m | m_wen);
            if (w_en_out) begin
                check("no_back_to_back_write", prev_wen, 1'b0);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1'b1, 1'b0);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("fifo_out_data", fifo_out_data, exp_word);
                end
                wlog.push_back(fifo_out_data[1:0]);
            end
            prev_wen = w_en_out;
        end else begin
            prev_wen = 1'b0;
        end
    end

    // ---------------- driver ----------------
    task automatic send_add(input logic [15:0] r, input logic [7:0] i);
        int s;
        s = acc_a;
        a_valid_result = 1'b1; add_result = r; id_add_out = i;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (acc_a != s) break;
        end
        check("add_accept_timeout", acc_a != s, 1'b1);
        a_valid_result = 1'b0;
    endtask

    task automatic send_mul(input logic [15:0] r, input logic [7:0] i);
        int s;
        s = acc_m;
        m_valid_result = 1'b1; mul_result = r; id_mul_out = i;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (acc_m != s) break;
        end
        check("mul_accept_timeout", acc_m != s, 1'b1);
        m_valid_result = 1'b0;
    endtask

    task automatic contest(input logic [15:0] ra, input logic [15:0] rm, input logic [7:0] i);
        fork
            send_add(ra, i);
            send_mul(rm, i + 8'd1);
        join
        repeat (6) @(negedge clk);
    endtask

    logic [1:0] exp_order[4];
    int         base, sa, sm;

    initial begin
        // reset state
        #12;
        check("rst_w_en", w_en_out, 1'b0);
        check("rst_data", fifo_out_data, 26'h0);
        check("rst_a_ready", a_ready_result, 1'b1);
        check("rst_m_ready", m_ready_result, 1'b1);
        check("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: adder only, write pulse one cycle after the capture is visible
        send_add(16'h1234, 8'h05);
        @(negedge clk);
        check("t1_w_en", w_en_out, 1'b1);
        check("t1_data", fifo_out_data, {16'h1234, 8'h05, 2'b01});
        repeat (3) @(negedge clk);

        // 2: multiplier only
        send_mul(16'h00E1, 8'hA0);
        @(negedge clk);
        check("t2_data", fifo_out_data, {16'h00E1, 8'hA0, 2'b10});
        @(negedge clk);
        check("t2_m_ready", m_ready_result, 1'b1);
        repeat (3) @(negedge clk);

        // 3: two contests
        wlog.delete();
        contest(16'h1111, 16'h2222, 8'h10);
        contest(16'h3333, 16'h4444, 8'h20);
`ifdef OUT_ALU_RR_ARB_EN
        exp_order = '{2'b01, 2'b10, 2'b10, 2'b01};
`else
        exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        check("t3_write_count", wlog.size(), 4);
        for (int k = 0; k < 4 && k < wlog.size(); k++)
            check("t3_order", wlog[k], exp_order[k]);

        // 4: FIFO_OUT full holds the result and back-pressures the adder
        full_out = 1'b1;
        send_add(16'hBEEF, 8'h33);
        base = wlog.size();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("t4_held_ready", a_ready_result, 1'b0);
            check("t4_no_write", w_en_out, 1'b0);
        end
        full_out = 1'b0;
        repeat (5) @(negedge clk);
        check("t4_one_write", wlog.size() - base, 1);

        // 5: 8 back-to-back adder results in ID order
        base = wlog.size();
        for (int k = 0; k < 8; k++) send_add(16'h0100 + 16'(k), 8'(k));
        repeat (5) @(negedge clk);
        check("t5_write_count", wlog.size() - base, 8);

        // randomized traffic with random FIFO_OUT full
        sa = acc_a; sm = acc_m;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (!a_valid_result || acc_a != sa) begin
                a_valid_result = ($urandom_range(0, 2) != 0);
                add_result = 16'($urandom); id_add_out = 8'($urandom);
                sa = acc_a;
            end
            if (!m_valid_result || acc_m != sm) begin
                m_valid_result = ($urandom_range(0, 2) != 0);
                mul_result = 16'($urandom); id_mul_out = 8'($urandom);
                sm = acc_m;
            end
            full_out = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        a_valid_result = 1'b0; m_valid_result = 1'b0; full_out = 1'b0;
        repeat (10) @(negedge clk);
        check("drain_empty", exp_q.size(), 0);

        // 6: reset while a write is in flight and the multiplier is held
        full_out = 1'b1;
        fork
            send_add(16'hAAAA, 8'h61);
            send_mul(16'h5555, 8'h62);
        join
        full_out = 1'b0;
        @(negedge clk);
        check("t6_w_en_before", w_en_out, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_w_en", w_en_out, 1'b0);
        check("t6_data", fifo_out_data, 26'h0);
        check("t6_a_ready", a_ready_result, 1'b1);
        check("t6_m_ready", m_ready_result, 1'b1);
        check("t6_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        base = wlog.size();
        repeat (10) @(negedge clk);
        check("t6_no_write_after", wlog.size() - base, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
